mem_stage_ctrl: RTL and testbench

//  Parametrised pipeline memory stage; replaces the fixed single-cycle 16-bit memory hookup.

---
 rtl/mem_stage_ctrl_if.sv | 25 ++
 rtl/mem_stage_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory port between the pipeline memory stage and a variable-latency memory.
interface mem_stage_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Pipeline memory stage: byte/half/word loads and stores over a req/ack port,
// stalling the pipe until ack, with flush kill, misalignment and timeout handling.
module mem_stage_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              misalign,
  output logic              timeout,
  mem_stage_ctrl_if.master  mem
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              kill_q, kill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              misalign_d, timeout_d;

  logic              access;
  logic              aligned;
  logic [BE_W-1:0]   lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] load_data;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;

  assign alu_out       = alu_res;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_be    = be_q;

  // Request decode: alignment, byte enables and lane-replicated store data.
  always_comb begin
    access     = (mem_read | mem_write) & ~flush;
    aligned    = 1'b1;
    lane_be    = BE_W'(4'b1111);
    lane_wdata = wr_data;
    case (size)
      2'b00: begin
        lane_be    = BE_W'(4'b0001) << alu_res[1:0];
        lane_wdata = DATA_W'({4{wr_data[7:0]}});
      end
      2'b01: begin
        aligned    = ~alu_res[0];
        lane_be    = alu_res[1] ? BE_W'(4'b1100) : BE_W'(4'b0011);
        lane_wdata = DATA_W'({2{wr_data[15:0]}});
      end
      default: aligned = (alu_res[1:0] == 2'b00);
    endcase
  end

  // Load formatting: pick the addressed lane of the captured word and extend it.
  always_comb begin
    load_byte = rdata_q[{alu_res[1:0], 3'b000} +: 8];
    load_half = rdata_q[{alu_res[1], 4'b0000} +: 16];
    case (size)
      2'b00:   load_data = {{(DATA_W-8){sign_ext & load_byte[7]}}, load_byte};
      2'b01:   load_data = {{(DATA_W-16){sign_ext & load_half[15]}}, load_half};
      default: load_data = rdata_q;
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    kill_d     = kill_q;
    cnt_d      = cnt_q;
    misalign_d = 1'b0;
    timeout_d  = 1'b0;
    stall      = 1'b0;
    wb_data    = alu_res;
    case (state_q)
      IDLE: begin
        if (access && aligned) begin
          stall   = 1'b1;
          req_d   = 1'b1;
          we_d    = ~mem_read;
          addr_d  = {alu_res[ADDR_W-1:2], 2'b00};
          wdata_d = lane_wdata;
          be_d    = lane_be;
          cnt_d   = '0;
          kill_d  = 1'b0;
          state_d = WAIT;
        end else if (access) begin
          misalign_d = 1'b1;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (mem.mem_ack) begin
          rdata_d = mem.mem_rdata;
          req_d   = 1'b0;
          kill_d  = 1'b0;
          if (kill_q || flush) begin
            // Killed access: release the pipe now and never format the data.
            stall   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
          req_d     = 1'b0;
          kill_d    = 1'b0;
          stall     = 1'b0;
          wb_data   = '0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
          if (flush) kill_d = 1'b1;
        end
      end
      DONE: begin
        if (!we_q) wb_data = load_data;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      kill_q   <= 1'b0;
      cnt_q    <= '0;
      misalign <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
      kill_q   <= kill_d;
      cnt_q    <= cnt_d;
      misalign <= misalign_d;
      timeout  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: cycle model checked every cycle plus directed literal checks.
module tb_mem_stage_ctrl;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0, mem_read = 1'b0, mem_write = 1'b0, sign_ext = 1'b0;
  logic [1:0]    size = 2'b00;
  logic [DW-1:0] alu_res = '0, wr_data = '0, rdata = '0;
  logic          ack = 1'b0;
  logic [DW-1:0] alu_out, wb_data;
  logic          stall, misalign, timeout;

  int tests = 0;
  int fails = 0;
  int stall_seen = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) mbus ();
  assign mbus.mem_rdata = rdata;
  assign mbus.mem_ack   = ack;

  mem_stage_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .flush(flush), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .sign_ext(sign_ext), .alu_res(alu_res), .wr_data(wr_data),
    .alu_out(alu_out), .wb_data(wb_data), .stall(stall), .misalign(misalign),
    .timeout(timeout), .mem(mbus.master)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Loaded value from the rules: shift the lane down, mask to width, extend.
  function automatic logic [31:0] m_fmt(input logic [31:0] d, input logic [31:0] a,
                                        input logic [1:0] sz, input logic sx);
    int nb;
    logic [63:0] v, mask;
    nb   = nbytes(sz);
    v    = {32'b0, d} >> (8 * (a % 4));
    mask = (64'd1 << (8 * nb)) - 64'd1;
    v    = v & mask;
    if (sx && nb < 4 && v[8*nb-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // Behavioural model, checked on every falling edge.
  logic        m_busy, m_done, m_kill, m_req, m_we, m_mis, m_to;
  int          m_cnt;
  logic [15:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_be;

  initial begin : model
    logic        e_stall, n_mis, n_to;
    logic [31:0] e_wb;
    int          nb;
    logic        acc;
    m_busy = 0; m_done = 0; m_kill = 0; m_req = 0; m_we = 0; m_mis = 0; m_to = 0;
    m_cnt = 0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_be = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_busy = 0; m_done = 0; m_kill = 0; m_req = 0; m_we = 0; m_mis = 0; m_to = 0;
        m_cnt = 0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_be = 0;
        chk("rst_mem_req", 32'(mbus.mem_req), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
      end else begin
        chk("alu_out", alu_out, alu_res);
        chk("mem_req", 32'(mbus.mem_req), 32'(m_req));
        chk("misalign", 32'(misalign), 32'(m_mis));
        chk("timeout", 32'(timeout), 32'(m_to));
        if (m_req) begin
          chk("mem_we", 32'(mbus.mem_we), 32'(m_we));
          chk("mem_addr", 32'(mbus.mem_addr), 32'(m_addr));
          chk("mem_be", 32'(mbus.mem_be), 32'(m_be));
          chk("mem_wdata", mbus.mem_wdata, m_wdata);
        end
        n_mis = 0; n_to = 0; e_stall = 0; e_wb = alu_res;
        nb  = nbytes(size);
        acc = (mem_read || mem_write) && !flush;
        if (m_done) begin
          if (!m_we) e_wb = m_fmt(m_rdata, alu_res, size, sign_ext);
          m_done = 0;
        end else if (m_busy) begin
          if (ack) begin
            m_rdata = rdata; m_req = 0; m_busy = 0;
            if (m_kill || flush) m_kill = 0;
            else begin e_stall = 1; m_done = 1; end
          end else if (m_cnt == int'(TO)) begin
            e_wb = 0; n_to = 1; m_req = 0; m_busy = 0; m_kill = 0;
          end else begin
            e_stall = 1; m_cnt++;
            if (flush) m_kill = 1;
          end
        end else if (acc && (alu_res % nb) == 0) begin
          e_stall = 1; m_busy = 1; m_cnt = 0; m_kill = 0; m_req = 1;
          m_we    = !mem_read;
          m_addr  = alu_res[15:0] & 16'hFFFC;
          m_be    = 4'(((1 << nb) - 1) << (alu_res % 4));
          m_wdata = (nb == 1) ? wr_data[7:0] * 32'h01010101 :
                    (nb == 2) ? wr_data[15:0] * 32'h00010001 : wr_data;
        end else if (acc) begin
          n_mis = 1;
        end
        chk("stall", 32'(stall), 32'(e_stall));
        if (!e_stall) chk("wb_data", wb_data, e_wb);
        if (stall) stall_seen++;
        m_mis = n_mis; m_to = n_to;
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    mem_read = 0; mem_write = 0; flush = 0; size = 2'b00; sign_ext = 0; wr_data = 0;
  endtask

  task automatic byte_load(input logic sx, input logic [31:0] exp);
    int s0;
    s0 = stall_seen;
    mem_read = 1; size = 2'b00; sign_ext = sx; alu_res = 32'h0013;
    cyc();
    chk("b_be", 32'(mbus.mem_be), 32'h8);
    ack = 1; rdata = 32'h80FF_0011;
    cyc(); ack = 0; #1;
    chk("b_wb", wb_data, exp);
    chk("b_done_stall", 32'(stall), 32'd0);
    cyc(); idle_in();
    chk("b_stall_cycles", 32'(stall_seen - s0), 32'd2);
  endtask

  initial begin : stim
    int s0;
    #1 rst = 1;
    #1;
    chk("r_mem_req", 32'(mbus.mem_req), 32'd0);
    chk("r_mem_we", 32'(mbus.mem_we), 32'd0);
    chk("r_mem_addr", 32'(mbus.mem_addr), 32'd0);
    chk("r_mem_wdata", mbus.mem_wdata, 32'd0);
    chk("r_mem_be", 32'(mbus.mem_be), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // No access: passthrough
    alu_res = 32'h1234;
    cyc(); cyc(); #1;
    chk("t1_wb", wb_data, 32'h1234);
    chk("t1_stall", 32'(stall), 32'd0);
    chk("t1_req", 32'(mbus.mem_req), 32'd0);

    // Word store, ack in the third WAIT cycle
    cyc();
    s0 = stall_seen;
    mem_write = 1; size = 2'b10; alu_res = 32'h0010; wr_data = 32'hDEADBEEF;
    #1 chk("t2_stall_req", 32'(stall), 32'd1);
    cyc();
    chk("t2_req", 32'(mbus.mem_req), 32'd1);
    chk("t2_we", 32'(mbus.mem_we), 32'd1);
    chk("t2_be", 32'(mbus.mem_be), 32'hF);
    chk("t2_addr", 32'(mbus.mem_addr), 32'h0010);
    chk("t2_wdata", mbus.mem_wdata, 32'hDEADBEEF);
    cyc(); cyc(); ack = 1;
    cyc(); ack = 0; #1;
    chk("t2_done_stall", 32'(stall), 32'd0);
    chk("t2_done_req", 32'(mbus.mem_req), 32'd0);
    cyc(); idle_in();
    chk("t2_stall_cycles", 32'(stall_seen - s0), 32'd4);

    // Byte loads, signed and unsigned
    cyc();
    byte_load(1'b1, 32'hFFFF_FF80);
    byte_load(1'b0, 32'h0000_0080);

    // Half load upper lane, signed
    mem_read = 1; size = 2'b01; sign_ext = 1; alu_res = 32'h0012;
    cyc();
    chk("h_be", 32'(mbus.mem_be), 32'hC);
    ack = 1; rdata = 32'h80FF_0011;
    cyc(); ack = 0; #1;
    chk("h_wb", wb_data, 32'hFFFF_80FF);
    cyc(); idle_in();

    // Misaligned half load
    mem_read = 1; size = 2'b01; alu_res = 32'h0011;
    #1 chk("t4_stall", 32'(stall), 32'd0);
    chk("t4_wb", wb_data, 32'h0011);
    cyc(); idle_in(); #1;
    chk("t4_misalign", 32'(misalign), 32'd1);
    chk("t4_req", 32'(mbus.mem_req), 32'd0);
    cyc();
    chk("t4_pulse_end", 32'(misalign), 32'd0);

    // Flush during WAIT of a load, then ack
    mem_read = 1; size = 2'b10; alu_res = 32'h0020;
    cyc(); flush = 1;
    cyc(); flush = 0; ack = 1; rdata = 32'hCAFEF00D; #1;
    chk("t5_ack_stall", 32'(stall), 32'd0);
    chk("t5_ack_wb", wb_data, 32'h0020);
    cyc(); ack = 0; idle_in(); #1;
    chk("t5_req", 32'(mbus.mem_req), 32'd0);
    chk("t5_idle_wb", wb_data, 32'h0020);
    cyc();

    // Load timeout with no ack
    s0 = stall_seen;
    mem_read = 1; size = 2'b10; alu_res = 32'h0040;
    repeat (5) cyc();
    chk("t6_to_stall", 32'(stall), 32'd0);
    chk("t6_to_wb", wb_data, 32'd0);
    cyc(); idle_in(); #1;
    chk("t6_timeout", 32'(timeout), 32'd1);
    chk("t6_req", 32'(mbus.mem_req), 32'd0);
    chk("t6_stall_cycles", 32'(stall_seen - s0), 32'd5);
    cyc();
    chk("t6_pulse_end", 32'(timeout), 32'd0);

    // Async reset in the middle of a byte store
    mem_write = 1; size = 2'b00; alu_res = 32'h0045; wr_data = 32'h0000_00A5;
    cyc();
    chk("t7_wdata", mbus.mem_wdata, 32'hA5A5A5A5);
    chk("t7_be", 32'(mbus.mem_be), 32'h2);
    cyc();
    #2 rst = 1; idle_in();
    #1;
    chk("t7_req", 32'(mbus.mem_req), 32'd0);
    chk("t7_we", 32'(mbus.mem_we), 32'd0);
    chk("t7_addr", 32'(mbus.mem_addr), 32'd0);
    chk("t7_wdata0", mbus.mem_wdata, 32'd0);
    chk("t7_be0", 32'(mbus.mem_be), 32'd0);
    chk("t7_stall", 32'(stall), 32'd0);
    cyc(); rst = 0;

    // Stray ack while idle is ignored
    ack = 1; rdata = 32'h1111_2222;
    cyc(); ack = 0; #1;
    chk("t8_req", 32'(mbus.mem_req), 32'd0);
    chk("t8_stall", 32'(stall), 32'd0);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
